clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Controller and sequencer for the team's clock-divider/gating datapath. Produces a registered, glitch-free divided clock with a programmable ratio, plus a one-cycle period tick.
- Start, stop and ratio changes happen only at period boundaries.
- Sits between a config master (valid/ready) and the divided-clock consumers; replaces the ad-hoc toggle-and-AND clock generation.

Parameters:
- CNT_W, 8, width of the divide ratio and the period counter.
- DEFAULT_DIV, 2, divide ratio loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request, level-sensitive.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  CNT_W  requested ratio N.
- cfg_ready  out  1  controller can accept a ratio.
- cfg_err  out  1  one-cycle pulse: accepted ratio was invalid and discarded.
- div_clk_o  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on the last clk of each divided period.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0, div_reg=DEFAULT_DIV, pend_vld=0.
  - div_clk_o=0, tick=0, cfg_err=0, busy=0, cfg_ready=1.
- States:
  - IDLE: cnt held at 0, div_clk_o=0. If en=1, go to RUN next cycle.
  - RUN: cnt counts 0..div_reg-1 and wraps. If en=0 at any point, go to STOP.
  - STOP: continue counting to the period end, then IDLE. If en returns to 1 while in STOP, go back to RUN with no period interruption.
- Waveform in RUN/STOP:
  - div_clk_o=1 while cnt < H, where H = div_reg - (div_reg>>1) (high phase is the ceiling for odd N); else 0.
  - Output is registered and changes only on clk.
  - The first RUN cycle has cnt=0, so div_clk_o=1 one cycle after en is sampled high.
- Period boundary: cnt==div_reg-1.
  - tick=1 for that cycle only.
  - Next cnt=0.
  - If pend_vld, then div_reg<=pend_div and pend_vld<=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = ~pend_vld.
- Validity: cfg_div < 2 is invalid. An invalid ratio is accepted (handshake completes), discarded, and raises cfg_err for one cycle, starting the cycle after the transfer. No state change.
- Valid ratio in IDLE: div_reg updates the next cycle.
- Valid ratio in RUN/STOP: stored in pend_div with pend_vld=1 and applied at the next period boundary. The current period always completes with the old ratio.
- Transfer on the same cycle as a boundary: it is pending, and the ratio applies at the following boundary.
- Simultaneous en fall and cfg transfer: both honoured. The period ends, the pending ratio is applied, then the block enters IDLE.
- A pending ratio in IDLE cannot occur. STOP always drains pend_vld at its boundary.
- Reset mid-period: immediate return to reset values. pend_div is discarded and div_clk_o drops asynchronously to 0.
- Counter width: cnt is CNT_W bits and never exceeds div_reg-1. No overflow is possible for a valid div_reg.

Decomposition:
- Package clk_div_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, STOP=2'd2.
  - MIN_DIV=2.
  - Default CNT_W.
- Sub-module clk_div_core: period counter, high-phase compare, tick and registered div_clk_o. Inputs are run/clear/div_reg.
- clk_div_ctrl owns the FSM, the config handshake and the pending register.

Test Plan:
1. Reset, then en=1 with DEFAULT_DIV=2 -> div_clk_o pattern 1,0,1,0 starting one cycle after en; tick on every second cycle; busy=1.
2. In IDLE, cfg_div=5 with valid → ready transfer, then en=1 -> div_clk_o 1,1,1,0,0 repeating; tick on the cycle with cnt=4.
3. Running at N=4, send cfg_div=3 at cnt=1 -> cfg_ready drops next cycle; the current period finishes as 1,1,0,0; the next period is 1,1,0; cfg_ready returns to 1 after the boundary.
4. cfg_div=1 and cfg_div=0 sent while running -> each gets a one-cycle cfg_err; waveform unchanged; cfg_ready stays 1.
5. N=6, drop en at cnt=2 -> STOP; the period completes (3 high, 3 low); then IDLE with div_clk_o=0 and busy=0. Repeat with en reasserted at cnt=4 -> no gap between periods.
6. Assert rst=0 mid-high-phase with pend_vld=1 -> div_clk_o=0 immediately; after release, the ratio equals DEFAULT_DIV and cfg_ready=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock controller.
package clk_div_pkg;

    // Default width of the divide ratio and of the period counter.
    localparam int CNT_W_DEFAULT = 8;

    // Smallest ratio that still yields a high phase and a low phase.
    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    // Length of the high phase for ratio n: the ceiling of n/2, so odd
    // ratios carry the extra cycle in the high phase.
    function automatic int unsigned high_phase(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and registered divided-clock generator.
// run_i says the current cycle belongs to a period; run_next_i says the
// following cycle will too. The output register is loaded from the next
// counter value, so div_clk_o stays phase-aligned with the counter and
// rises in the very first cycle of a period.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             run_next_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             tick_o,
    output logic             div_clk_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             div_clk_q;
    logic             div_clk_d;
    logic             last_cnt;

    assign last_cnt  = (cnt_q == div_i - CNT_W'(1));
    assign tick_o    = run_i && last_cnt;
    assign div_clk_o = div_clk_q;

    // Next counter value and next divided-clock level.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cnt_d = '0;
        if (run_i && !last_cnt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A changed ratio only takes effect when cnt_d is 0, and 0 is always
        // inside the high phase, so comparing against the current ratio is safe.
        div_clk_d = run_next_i && (32'(cnt_d) < high_phase(32'(div_i)));
    end

    // Counter and output registers; reset forces the clock low at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples values from before the edge.
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop sequencing, ratio configuration
// handshake and the pending-ratio register. Starting, stopping and ratio
// changes all take effect on period boundaries.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk_o,
    output logic             tick,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] div_reg_q;
    logic [CNT_W-1:0] div_reg_d;
    logic [CNT_W-1:0] pend_div_q;
    logic [CNT_W-1:0] pend_div_d;
    logic             pend_vld_q;
    logic             pend_vld_d;
    logic             cfg_err_q;
    logic             cfg_err_d;

    logic running;
    logic run_next;
    logic period_end;
    logic xfer;
    logic ratio_ok;

    assign running   = (state_q != IDLE);
    assign run_next  = (state_d != IDLE);
    assign cfg_ready = ~pend_vld_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign ratio_ok  = (cfg_div >= CNT_W'(MIN_DIV));
    assign busy      = running;
    assign cfg_err   = cfg_err_q;
    assign tick      = period_end;

    clk_div_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .run_i     (running),
        .run_next_i(run_next),
        .div_i     (div_reg_q),
        .tick_o    (period_end),
        .div_clk_o (div_clk_o)
    );

    // Run/stop sequencing: a started period always completes, and en
    // sampled in the last cycle of a period decides whether another follows.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) state_d = period_end ? IDLE : STOP;
            end
            STOP: begin
                if (en)              state_d = RUN;
                else if (period_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ratio bookkeeping: apply a pending ratio at the boundary, accept new
    // ratios, flag invalid ones.
    always_comb begin
        div_reg_d  = div_reg_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = 1'b0;

        if (period_end && pend_vld_q) begin
            div_reg_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end

        // xfer implies no pending ratio, so this never collides with the
        // boundary update above.
        if (xfer) begin
            if (!ratio_ok) begin
                cfg_err_d = 1'b1;
            end else if (state_q == IDLE || state_d == IDLE) begin
                // Idle now, or idle after this final boundary: nothing is
                // running, so load directly and never leave a ratio pending
                // while idle.
                div_reg_d = cfg_div;
            end else begin
                pend_div_d = cfg_div;
                pend_vld_d = 1'b1;
            end
        end
    end

    // Controller registers; reset discards any pending ratio.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_reg_q  <= CNT_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_reg_q  <= div_reg_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl. The reference model treats the
// output as a sequence of whole periods: a period, once started, runs to
// completion with its ratio fixed, and en in its last cycle decides whether
// another one starts. Ratios offered during a period wait in a queue of
// depth one until that period ends.
module tb_clk_div_ctrl;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk_o;
    logic             tick;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .div_clk_o(div_clk_o),
        .tick     (tick),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_on;
    int m_pos;
    int m_ratio;
    int m_pend[$];
    bit m_err;

    logic exp_div, exp_tick, exp_busy, exp_ready, exp_err;

    task automatic model_outputs();
        exp_div   = m_on && (m_pos < (m_ratio + 1) / 2);
        exp_tick  = m_on && (m_pos == m_ratio - 1);
        exp_busy  = m_on;
        exp_ready = (m_pend.size() == 0);
        exp_err   = m_err;
    endtask

    task automatic model_reset();
        m_on    = 0;
        m_pos   = 0;
        m_ratio = DEFAULT_DIV;
        m_pend.delete();
        m_err   = 0;
        model_outputs();
    endtask

    task automatic model_step(input bit e, input bit v, input int d);
        bit xfer;
        bit was_on;
        bit last;
        xfer   = v && (m_pend.size() == 0);
        was_on = m_on;
        last   = m_on && (m_pos == m_ratio - 1);
        m_err  = xfer && (d < 2);
        if (m_on) begin
            if (last) begin
                if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
                m_pos = 0;
                m_on  = e;
            end else begin
                m_pos++;
            end
        end else if (e) begin
            m_on  = 1;
            m_pos = 0;
        end
        if (xfer && d >= 2) begin
            if (!was_on || (last && !e)) m_ratio = d;
            else                         m_pend.push_back(d);
        end
        model_outputs();
    endtask

    // One clock cycle: drive inputs, step the model with them at the edge,
    // then settle so outputs can be sampled away from the edge.
    task automatic cyc(input bit e, input bit v, input int d);
        en        = e;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        @(posedge clk);
        model_step(e, v, d);
        #1;
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            cyc(0, 0, 0);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_busy !== 1'b0) begin
            failures++;
            $display("FAIL go_idle: busy=%0b model_busy=%0b after %0d cycles", busy, exp_busy, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        #12;
        checks++;
        if ({div_clk_o, tick, cfg_err, busy, cfg_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs: div/tick/err/busy/ready=%b expected 00001",
                     {div_clk_o, tick, cfg_err, busy, cfg_ready});
        end
        rst = 1'b1;
        cyc(0, 0, 0);
        checks++;
        if (busy !== 1'b0 || div_clk_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_hold: busy=%0b div=%0b expected 0 0", busy, div_clk_o);
        end
    endtask

    task automatic test_default_run();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0);
            checks++;
            if (div_clk_o !== ((i % 2) == 0) || tick !== ((i % 2) == 1) || busy !== 1'b1) begin
                failures++;
                $display("FAIL default_run[%0d]: div=%0b tick=%0b busy=%0b expected %0b %0b 1",
                         i, div_clk_o, tick, busy, (i % 2) == 0, (i % 2) == 1);
            end
        end
        go_idle();
    endtask

    task automatic test_ratio_idle();
        cyc(0, 1, 5);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL ratio_idle_xfer: ready=%0b busy=%0b err=%0b expected 1 0 0",
                     cfg_ready, busy, cfg_err);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0);
            checks++;
            if (div_clk_o !== ((i % 5) < 3) || tick !== ((i % 5) == 4)) begin
                failures++;
                $display("FAIL ratio5[%0d]: div=%0b tick=%0b expected %0b %0b",
                         i, div_clk_o, tick, (i % 5) < 3, (i % 5) == 4);
            end
        end
        go_idle();
    endtask

    task automatic test_pending();
        logic exp_d[6] = '{0, 0, 1, 1, 0, 1};
        logic exp_t[6] = '{0, 1, 0, 0, 1, 0};
        logic exp_r[6] = '{0, 0, 1, 1, 1, 1};
        cyc(0, 1, 4);
        cyc(1, 0, 0);      // cnt 0
        cyc(1, 0, 0);      // cnt 1
        cyc(1, 1, 3);      // transfer during cnt 1
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1, 0, 0);
            checks++;
            if (div_clk_o !== exp_d[i] || tick !== exp_t[i] || cfg_ready !== exp_r[i]) begin
                failures++;
                $display("FAIL pending[%0d]: div=%0b tick=%0b ready=%0b expected %0b %0b %0b",
                         i, div_clk_o, tick, cfg_ready, exp_d[i], exp_t[i], exp_r[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_invalid();
        int codes[2] = '{1, 0};
        cyc(0, 1, 3);
        repeat (4) cyc(1, 0, 0);
        foreach (codes[k]) begin
            cyc(1, 1, codes[k]);
            checks++;
            if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || div_clk_o !== exp_div) begin
                failures++;
                $display("FAIL invalid_%0d: err=%0b ready=%0b div=%0b expected 1 1 %0b",
                         codes[k], cfg_err, cfg_ready, div_clk_o, exp_div);
            end
            cyc(1, 0, 0);
            checks++;
            if (cfg_err !== 1'b0 || div_clk_o !== exp_div || tick !== exp_tick) begin
                failures++;
                $display("FAIL invalid_%0d_after: err=%0b div=%0b tick=%0b expected 0 %0b %0b",
                         codes[k], cfg_err, div_clk_o, tick, exp_div, exp_tick);
            end
        end
        // Ratio must still be 3 (pattern 1,1,0) after the discarded codes.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0);
            checks++;
            if (div_clk_o !== exp_div || m_ratio != 3) begin
                failures++;
                $display("FAIL invalid_wave[%0d]: div=%0b expected %0b (model ratio %0d)",
                         i, div_clk_o, exp_div, m_ratio);
            end
        end
        go_idle();
    endtask

    task automatic test_stop();
        bit   en_a[7]  = '{1, 1, 1, 0, 0, 0, 0};
        logic d_a[7]   = '{1, 1, 1, 0, 0, 0, 0};
        logic b_a[7]   = '{1, 1, 1, 1, 1, 1, 0};
        logic t_a[7]   = '{0, 0, 0, 0, 0, 1, 0};
        bit   en_b[9]  = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
        logic d_b[9]   = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        logic t_b[9]   = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        cyc(0, 1, 6);
        for (int i = 0; i < 7; i++) begin
            cyc(en_a[i], 0, 0);
            checks++;
            if (div_clk_o !== d_a[i] || busy !== b_a[i] || tick !== t_a[i]) begin
                failures++;
                $display("FAIL stop[%0d]: div=%0b busy=%0b tick=%0b expected %0b %0b %0b",
                         i, div_clk_o, busy, tick, d_a[i], b_a[i], t_a[i]);
            end
        end
        for (int i = 0; i < 9; i++) begin
            cyc(en_b[i], 0, 0);
            checks++;
            if (div_clk_o !== d_b[i] || busy !== 1'b1 || tick !== t_b[i]) begin
                failures++;
                $display("FAIL stop_resume[%0d]: div=%0b busy=%0b tick=%0b expected %0b 1 %0b",
                         i, div_clk_o, busy, tick, d_b[i], t_b[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 4);
        cyc(1, 0, 0);      // cnt 0, high
        cyc(1, 1, 7);      // pending ratio, cnt 1, still high
        checks++;
        if (div_clk_o !== 1'b1 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_setup: div=%0b ready=%0b expected 1 0", div_clk_o, cfg_ready);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (div_clk_o !== 1'b0 || busy !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_async: div=%0b busy=%0b tick=%0b ready=%0b expected 0 0 0 1",
                     div_clk_o, busy, tick, cfg_ready);
        end
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            checks++;
            if (div_clk_o !== ((i % 2) == 0) || cfg_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_default[%0d]: div=%0b ready=%0b expected %0b 1",
                         i, div_clk_o, cfg_ready, (i % 2) == 0);
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        bit e;
        bit v;
        int d;
        int bad;
        e   = 0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) e = ~e;
            v = ($urandom_range(0, 4) == 0);
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40))
                                             : int'($urandom_range(0, 7));
            cyc(e, v, d);
            checks++;
            if ({div_clk_o, tick, busy, cfg_ready, cfg_err} !==
                {exp_div, exp_tick, exp_busy, exp_ready, exp_err}) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: div/tick/busy/ready/err=%b expected %b",
                             i, {div_clk_o, tick, busy, cfg_ready, cfg_err},
                             {exp_div, exp_tick, exp_busy, exp_ready, exp_err});
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_ratio_idle();
        test_pending();
        test_invalid();
        test_stop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
